// File: rtl/clk_div_pkg.sv
// Shared constants, FSM encoding and helpers for the clk_divider_n slice.
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } div_state_t;

  // Number of phase steps clk_p spends high for divisor n.
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Phase counter, clk_p/clk_n generation and end-of-period pulse for clk_divider_n.
// ODD_DUTY50_EN builds the negedge copy of clk_p; without it clk_n simply mirrors clk_p.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             active,
  input  logic             run_next,
  output logic             last,
  output logic             clk_p,
  output logic             clk_n,
  output logic             clk_pulse
);

  logic [DIV_W-1:0] ph;
  logic [DIV_W-1:0] ph_next;
  logic [DIV_W-1:0] half;

  assign half    = DIV_W'(half_ceil(32'(div)));
  assign last    = active && (ph == div - DIV_W'(1));
  // Starting from IDLE or crossing a boundary both begin a fresh period at phase 0.
  assign ph_next = (!active || last) ? '0 : ph + DIV_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !run_next) begin
      ph        <= '0;
      clk_p     <= 1'b0;
      clk_pulse <= 1'b0;
    end else begin
      ph        <= ph_next;
      clk_p     <= (ph_next < half);
      clk_pulse <= (ph_next == div - DIV_W'(1));
    end
  end

`ifdef ODD_DUTY50_EN
  always_ff @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end
`else
  assign clk_n = clk_p;
`endif

endmodule

// File: rtl/clk_divider_n.sv
// Runtime-programmable 50%-duty clock divider with boundary-synchronous divisor updates.
// Define ODD_DUTY50_EN to get exact 50% duty for odd divisors via a negedge flop.
module clk_divider_n
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_num,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             clk_pulse,
  output logic [1:0]       fsm_state
);

  div_state_t       state;
  div_state_t       state_next;
  logic             active;
  logic             run_next;
  logic             last;
  logic             apply;
  logic             load_ok;
  logic             pend_vld;
  logic [DIV_W-1:0] pend_div;
  logic             clk_p;
  logic             clk_n;

  assign fsm_state = state;
  assign active    = (state != IDLE);
  assign run_next  = (state_next != IDLE);
  assign load_ok   = div_load && (div_num >= DIV_W'(MIN_DIV));
  // A pending divisor lands only where a period boundary (or idle) makes it glitch-free.
  assign apply     = pend_vld && (!active || last);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = div_en ? RUN : IDLE;
      RUN, STOP: begin
        if (last) state_next = div_en ? RUN : IDLE;
        else      state_next = div_en ? RUN : STOP;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cur_div  <= DIV_W'(DIV_DEFAULT);
      pend_vld <= 1'b0;
      pend_div <= '0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      state   <= state_next;
      div_ack <= apply;
      div_err <= div_load && !load_ok;
      if (apply) cur_div <= pend_div;
      if (load_ok) begin
        pend_vld <= 1'b1;
        pend_div <= div_num;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .div       (cur_div),
    .active    (active),
    .run_next  (run_next),
    .last      (last),
    .clk_p     (clk_p),
    .clk_n     (clk_n),
    .clk_pulse (clk_pulse)
  );

`ifdef ODD_DUTY50_EN
  assign clk_out = cur_div[0] ? (clk_p & clk_n) : clk_p;
`else
  assign clk_out = clk_p & clk_n;
`endif

endmodule

// File: tb/tb_clk_divider_n.sv
// Directed bench for clk_divider_n: table of divisors plus hand sequences for reload,
// error, stop/restart and reset corners. Period shape is measured in half-cycle samples.
module tb_clk_divider_n;

`ifdef ODD_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       div_en;
  logic [7:0] div_num;
  logic       div_load;
  logic       div_ack;
  logic       div_err;
  logic [7:0] cur_div;
  logic       clk_out;
  logic       clk_pulse;
  logic [1:0] fsm_state;

  clk_divider_n #(.DIV_W(8), .DIV_DEFAULT(5)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .div_en    (div_en),
    .div_num   (div_num),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .div_err   (div_err),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .clk_pulse (clk_pulse),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  typedef struct {
    int         per;
    int         hi;
    int         pulses;
    logic [7:0] div;
  } rec_t;

  typedef struct {
    logic [7:0] div;
    int         per;
    int         hi;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  rec_t        rec_q[$];
  rec_t        cur_rec;
  bit          rec_open = 1'b0;
  logic        prev_out = 1'b0;
  int          rise_cnt = 0;
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [39:0] exp_q[$];
  vec_t        vec[7];

  // Period monitor: samples 5 ns after every edge, one record per clk_out rise-to-rise.
  always begin
    @(posedge sys_clk or negedge sys_clk);
    #5;
    if (clk_out === 1'b1 && prev_out !== 1'b1) begin
      rise_cnt++;
      if (rec_open) rec_q.push_back(cur_rec);
      cur_rec.per    = 1;
      cur_rec.hi     = 1;
      cur_rec.pulses = 0;
      cur_rec.div    = cur_div;
      rec_open       = 1'b1;
    end else if (rec_open) begin
      cur_rec.per++;
      if (clk_out === 1'b1) cur_rec.hi++;
    end
    if (sys_clk) begin
      if (rec_open && clk_pulse === 1'b1) cur_rec.pulses++;
      if (div_ack === 1'b1) ack_cnt++;
      if (div_err === 1'b1) err_cnt++;
    end
    prev_out = clk_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    div_en    = 1'b0;
    div_load  = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    @(negedge sys_clk);
    div_num  = v;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
  endtask

  task automatic fresh_recs();
    rec_q.delete();
    rec_open = 1'b0;
  endtask

  task automatic wait_recs(input int n, input int budget);
    int c;
    c = 0;
    while (rec_q.size() < n && c < budget) begin
      @(posedge sys_clk);
      c++;
    end
    check("period wait", 32'(rec_q.size() >= n), 1);
  endtask

  task automatic expect_period(input logic [7:0] d, input int per, input int hi);
    exp_q.push_back({d, 16'(per), 16'(hi)});
  endtask

  // scoreboard: pop expected periods against measured ones
  task automatic check_recs(input string name);
    rec_t        r;
    logic [39:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rec_q.size() == 0) begin
        check({name, " count"}, 0, 1);
      end else begin
        r = rec_q.pop_front();
        check({name, " div"}, 32'(r.div), 32'(e[39:32]));
        check({name, " period"}, r.per, 32'(e[31:16]));
        check({name, " high"}, r.hi, 32'(e[15:0]));
        check({name, " pulses"}, r.pulses, 1);
      end
    end
  endtask

  initial begin
    int a0;
    int e0;
    int r0;
    int c;
    int hi3;
    int hi5;

    hi3 = DUTY50 ? 3 : 4;
    hi5 = DUTY50 ? 5 : 6;
    // divisor, period and high time in half-cycles
    vec[0] = '{8'd2,   4,   2};
    vec[1] = '{8'd3,   6,   hi3};
    vec[2] = '{8'd4,   8,   4};
    vec[3] = '{8'd5,   10,  hi5};
    vec[4] = '{8'd8,   16,  8};
    vec[5] = '{8'd9,   18,  DUTY50 ? 9 : 10};
    vec[6] = '{8'd255, 510, DUTY50 ? 255 : 256};

    sys_rst_n = 1'b0;
    div_en    = 1'b0;
    div_load  = 1'b0;
    div_num   = 8'd0;
    repeat (3) @(posedge sys_clk);
    #5;
    check("rst clk_out", 32'(clk_out), 0);
    check("rst clk_pulse", 32'(clk_pulse), 0);
    check("rst div_ack", 32'(div_ack), 0);
    check("rst div_err", 32'(div_err), 0);
    check("rst cur_div", 32'(cur_div), 5);
    check("rst state", 32'(fsm_state), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Table: load in IDLE, then measure two full periods.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      pulse_load(vec[i].div);
      check("idle ack delay", 32'(div_ack), 0);
      @(posedge sys_clk);
      #5;
      check("idle ack", 32'(div_ack), 1);
      check("idle cur_div", 32'(cur_div), 32'(vec[i].div));
      fresh_recs();
      @(negedge sys_clk);
      div_en = 1'b1;
      expect_period(vec[i].div, vec[i].per, vec[i].hi);
      expect_period(vec[i].div, vec[i].per, vec[i].hi);
      wait_recs(2, 6 * int'(vec[i].div) + 40);
      check_recs("vec");
      @(negedge sys_clk);
      div_en = 1'b0;
    end

    // Start latency with default divisor 5.
    do_reset();
    fresh_recs();
    @(negedge sys_clk);
    div_en = 1'b1;
    @(posedge sys_clk);
    #5;
    check("start clk_out", 32'(clk_out), DUTY50 ? 0 : 1);
    check("start state", 32'(fsm_state), 1);
    @(negedge sys_clk);
    #5;
    check("start clk_out half", 32'(clk_out), 1);

    // Reload 5 -> 4 mid-period.
    wait_recs(1, 40);
    rec_q.delete();
    a0 = ack_cnt;
    pulse_load(8'd4);
    expect_period(8'd5, 10, hi5);
    expect_period(8'd4, 8, 4);
    wait_recs(2, 60);
    check_recs("reload");
    check("reload acks", ack_cnt - a0, 1);
    check("reload cur_div", 32'(cur_div), 4);

    // Two loads within one period: last write wins, one ack.
    wait_recs(1, 40);
    rec_q.delete();
    a0 = ack_cnt;
    @(negedge sys_clk);
    div_num  = 8'd6;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_num  = 8'd3;
    @(negedge sys_clk);
    div_load = 1'b0;
    expect_period(8'd4, 8, 4);
    expect_period(8'd3, 6, hi3);
    wait_recs(2, 60);
    check_recs("double load");
    check("double load acks", ack_cnt - a0, 1);

    // Rejected load.
    a0 = ack_cnt;
    e0 = err_cnt;
    pulse_load(8'd1);
    check("err pulse", 32'(div_err), 1);
    @(posedge sys_clk);
    #5;
    check("err one cycle", 32'(div_err), 0);
    check("err cur_div", 32'(cur_div), 3);
    rec_q.delete();
    expect_period(8'd3, 6, hi3);
    expect_period(8'd3, 6, hi3);
    wait_recs(2, 60);
    check_recs("after err");
    check("err count", err_cnt - e0, 1);
    check("err no ack", ack_cnt - a0, 0);

    // Brief div_en drop (STOP -> RUN), then a full drop during the high phase.
    do_reset();
    fresh_recs();
    @(negedge sys_clk);
    div_en = 1'b1;
    wait_recs(1, 40);
    rec_q.delete();
    @(negedge sys_clk);
    div_en = 1'b0;
    @(posedge sys_clk);
    #5;
    check("stop state", 32'(fsm_state), 2);
    @(negedge sys_clk);
    div_en = 1'b1;
    @(posedge sys_clk);
    #5;
    check("resume state", 32'(fsm_state), 1);
    expect_period(8'd5, 10, hi5);
    expect_period(8'd5, 10, hi5);
    wait_recs(2, 60);
    check_recs("stop resume");
    rec_q.delete();
    @(negedge sys_clk);
    div_en = 1'b0;
    repeat (20) @(posedge sys_clk);
    #5;
    check("drop high", cur_rec.hi, hi5);
    check("drop pulses", cur_rec.pulses, 1);
    check("drop no rise", rec_q.size(), 0);
    check("drop clk_out", 32'(clk_out), 0);
    check("drop state", 32'(fsm_state), 0);

    // Reset mid-period with a pending divisor.
    do_reset();
    fresh_recs();
    r0 = rise_cnt;
    @(negedge sys_clk);
    div_en   = 1'b1;
    div_num  = 8'd7;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
    c = 0;
    while (rise_cnt == r0 && c < 40) begin
      @(posedge sys_clk or negedge sys_clk);
      #6;
      c++;
    end
    check("rst rise seen", 32'(rise_cnt != r0), 1);
    a0 = ack_cnt;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #5;
    check("mid rst clk_out", 32'(clk_out), 0);
    check("mid rst cur_div", 32'(cur_div), 5);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    div_en    = 1'b0;
    repeat (8) @(posedge sys_clk);
    #5;
    check("post rst cur_div", 32'(cur_div), 5);
    check("post rst no ack", ack_cnt - a0, 0);
    check("post rst clk_out", 32'(clk_out), 0);
    check("post rst state", 32'(fsm_state), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
